// File: rtl/dmux8way16_frame_rx_pkg.sv
// Shared types and constants for the dmux8way16 frame receiver.
// Holds the FSM state encoding, slot geometry and the slot-to-lane decode.
package dmux8way16_frame_rx_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } rx_state_e;

  localparam int unsigned N_SLOTS = 8;
  localparam int unsigned SLOT_W  = 3;

  // One-hot lane write enable for a given frame slot.
  function automatic logic [N_SLOTS-1:0] slot_onehot(input logic [SLOT_W-1:0] slot);
    logic [N_SLOTS-1:0] oh;
    oh       = '0;
    oh[slot] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/dmux8way16_frame_rx_lane_reg.sv
// Single lane register: WIDTH-bit storage with synchronous reset and load enable.
module lane_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  // NOTE: lanes are plain flops, not a RAM, so resetting them is cheap and lets a reset visibly clear every lane.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/dmux8way16_frame_rx.sv
// Serial-to-parallel frame receiver: scatters 8 consecutive words into lanes a..h
// and holds the frame under a valid/ack handshake, with resync and idle-timeout abort.
module dmux8way16_frame_rx
  import dmux8way16_frame_rx_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  input  logic             in_sync,
  output logic             in_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] h,
  output logic             out_valid,
  input  logic             out_ack,
  output logic             frame_err
);

  localparam int TIMER_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  rx_state_e          state_q, state_d;
  logic [SLOT_W-1:0]  slot_q,  slot_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               err_q,   err_d;
  logic [N_SLOTS-1:0] lane_we;
  logic               accept;
  logic [WIDTH-1:0]   lane_q [N_SLOTS];

  // in_ready decodes registered state only, so it never loops back through in_valid.
  assign in_ready = (state_q != HOLD);
  assign accept   = in_valid && in_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      slot_q  <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    timer_d = timer_q;
    err_d   = 1'b0;
    lane_we = '0;
    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (accept) begin
          if (in_sync) begin
            lane_we = slot_onehot(SLOT_W'(0));
            slot_d  = SLOT_W'(1);
            state_d = COLLECT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (accept) begin
          timer_d = '0;
          if (in_sync) begin
            err_d   = 1'b1;
            lane_we = slot_onehot(SLOT_W'(0));
            slot_d  = SLOT_W'(1);
          end else begin
            lane_we = slot_onehot(slot_q);
            slot_d  = slot_q + 1'b1;
            if (slot_q == SLOT_W'(N_SLOTS - 1)) begin
              state_d = HOLD;
            end
          end
        end else if (TIMEOUT != 0) begin
          // Abort on the idle cycle that would bring the count up to TIMEOUT.
          if (timer_q == TIMER_LAST) begin
            err_d   = 1'b1;
            slot_d  = '0;
            timer_d = '0;
            state_d = IDLE;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      HOLD: begin
        timer_d = '0;
        if (out_ack) begin
          slot_d  = '0;
          state_d = IDLE;
        end
      end
      default: begin
        slot_d  = '0;
        timer_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  for (genvar i = 0; i < N_SLOTS; i++) begin : g_lane
    lane_reg #(.WIDTH(WIDTH)) u_lane (
      .clock  (clock),
      .reset  (reset),
      .load_i (lane_we[i]),
      .d_i    (in),
      .q_o    (lane_q[i])
    );
  end

  assign a = lane_q[0];
  assign b = lane_q[1];
  assign c = lane_q[2];
  assign d = lane_q[3];
  assign e = lane_q[4];
  assign f = lane_q[5];
  assign g = lane_q[6];
  assign h = lane_q[7];

  assign out_valid = (state_q == HOLD);
  assign frame_err = err_q;

endmodule

// File: tb/tb_dmux8way16_frame_rx.sv
// Directed bench for dmux8way16_frame_rx: a vector table for the handshake and
// hand-written sequences for resync, drop, timeout and reset corner cases.
module tb_dmux8way16_frame_rx;

  typedef struct {
    logic        v;
    logic        s;
    logic [15:0] d;
    logic        ack;
    logic        e_ready;
    logic        e_valid;
    logic        e_err;
    logic        chk_lanes;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] in_w = '0;
  logic        in_valid = 1'b0;
  logic        in_sync = 1'b0;
  logic        out_ack = 1'b0;

  logic        in_ready, out_valid, frame_err;
  logic [15:0] a, b, c, d, e, f, g, h;
  logic        in_ready_z, out_valid_z, frame_err_z;
  logic [15:0] a_z, b_z, c_z, d_z, e_z, f_z, g_z, h_z;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  dmux8way16_frame_rx #(.WIDTH(16), .TIMEOUT(15)) dut (
    .clock(clock), .reset(reset), .in(in_w), .in_valid(in_valid), .in_sync(in_sync),
    .in_ready(in_ready), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .out_valid(out_valid), .out_ack(out_ack), .frame_err(frame_err)
  );

  dmux8way16_frame_rx #(.WIDTH(16), .TIMEOUT(0)) dut_nt (
    .clock(clock), .reset(reset), .in(in_w), .in_valid(in_valid), .in_sync(in_sync),
    .in_ready(in_ready_z), .a(a_z), .b(b_z), .c(c_z), .d(d_z), .e(e_z), .f(f_z), .g(g_z), .h(h_z),
    .out_valid(out_valid_z), .out_ack(out_ack), .frame_err(frame_err_z)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic s, input logic [15:0] dw, input logic ack);
    in_valid = v;
    in_sync  = s;
    in_w     = dw;
    out_ack  = ack;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_sync  = 1'b0;
    out_ack  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 1'b0, 16'h0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic check_lanes(input string name, input logic [15:0] exp [8]);
    logic [15:0] act [8];
    act = '{a, b, c, d, e, f, g, h};
    for (int i = 0; i < 8; i++) check($sformatf("%s lane%0d", name, i), act[i], exp[i]);
  endtask

  task automatic check_lanes_nt(input string name, input logic [15:0] exp [8]);
    logic [15:0] act [8];
    act = '{a_z, b_z, c_z, d_z, e_z, f_z, g_z, h_z};
    for (int i = 0; i < 8; i++) check($sformatf("%s lane%0d", name, i), act[i], exp[i]);
  endtask

  task automatic check_ctl(input string name, input logic rdy, input logic vld, input logic err);
    check({name, " in_ready"}, in_ready, rdy);
    check({name, " out_valid"}, out_valid, vld);
    check({name, " frame_err"}, frame_err, err);
  endtask

  // Sends one full frame base..base+7 with sync on the first word, then checks HOLD.
  task automatic send_frame(input string name, input logic [15:0] base);
    logic [15:0] exp [8];
    for (int i = 0; i < 8; i++) begin
      step(1'b1, i == 0, base + 16'(i), 1'b0);
      exp[i] = base + 16'(i);
    end
    check_ctl(name, 1'b0, 1'b1, 1'b0);
    check_lanes(name, exp);
  endtask

  function automatic vec_t mk(input logic v, input logic s, input logic [15:0] dw, input logic ack,
                              input logic rdy, input logic vld, input logic err, input logic cl);
    vec_t r;
    r.v = v; r.s = s; r.d = dw; r.ack = ack;
    r.e_ready = rdy; r.e_valid = vld; r.e_err = err; r.chk_lanes = cl;
    return r;
  endfunction

  initial begin
    vec_t        vecs[$];
    logic [15:0] exp [8];
    logic [15:0] zeros [8];
    logic [15:0] frame1 [8];

    for (int i = 0; i < 8; i++) begin
      zeros[i]  = 16'h0;
      frame1[i] = 16'h1000 + 16'(i);
    end

    // Continuous frame, a held cycle with junk input, ack.
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1'b1, i == 0, 16'h1000 + 16'(i), 1'b0, i < 7, i == 7, 1'b0, i == 7));
    vecs.push_back(mk(1'b1, 1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 16'h0,    1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
    // Same frame with in_valid toggled every other cycle.
    for (int i = 0; i < 8; i++) begin
      vecs.push_back(mk(1'b1, i == 0, 16'h1000 + 16'(i), 1'b0, i < 7, i == 7, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b0, 16'h5555, 1'b0, i < 7, i == 7, 1'b0, i == 7));
    end
    vecs.push_back(mk(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));

    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    check_ctl("reset", 1'b1, 1'b0, 1'b0);
    check_lanes("reset", zeros);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].v, vecs[i].s, vecs[i].d, vecs[i].ack);
      check_ctl($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_valid, vecs[i].e_err);
      if (vecs[i].chk_lanes) check_lanes($sformatf("vec%0d", i), frame1);
    end

    // Early resync after 3 words.
    step(1'b1, 1'b1, 16'h2000, 1'b0);
    step(1'b1, 1'b0, 16'h2001, 1'b0);
    step(1'b1, 1'b0, 16'h2002, 1'b0);
    step(1'b1, 1'b1, 16'hBEEF, 1'b0);
    check_ctl("resync", 1'b1, 1'b0, 1'b1);
    exp[0] = 16'hBEEF;
    for (int i = 1; i < 8; i++) begin
      step(1'b1, 1'b0, 16'h3000 + 16'(i), 1'b0);
      exp[i] = 16'h3000 + 16'(i);
      check_ctl($sformatf("resync w%0d", i), i < 7, i == 7, 1'b0);
    end
    check_lanes("resync", exp);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    check_ctl("resync ack", 1'b1, 1'b0, 1'b0);

    // Non-sync word in IDLE is dropped.
    step(1'b1, 1'b0, 16'h0042, 1'b0);
    check_ctl("drop", 1'b1, 1'b0, 1'b1);
    check_lanes("drop", exp);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    check("drop pulse end", frame_err, 1'b0);

    // Timeout: 2 words then a 15-cycle gap aborts TIMEOUT=15 but not TIMEOUT=0.
    do_reset();
    step(1'b1, 1'b1, 16'h4000, 1'b0);
    step(1'b1, 1'b0, 16'h4001, 1'b0);
    for (int k = 1; k <= 100; k++) begin
      step(1'b0, 1'b0, 16'h0, 1'b0);
      if (k >= 14 && k <= 16) check($sformatf("timeout gap%0d", k), frame_err, k == 15);
      if (frame_err_z) check($sformatf("no-timeout gap%0d", k), frame_err_z, 1'b0);
    end
    check("no-timeout err idle", frame_err_z, 1'b0);
    for (int i = 2; i < 8; i++) begin
      step(1'b1, 1'b0, 16'h4000 + 16'(i), 1'b0);
      check($sformatf("aborted drop w%0d", i), frame_err, 1'b1);
    end
    check("timeout out_valid", out_valid, 1'b0);
    check("no-timeout out_valid", out_valid_z, 1'b1);
    check("timeout lane c untouched", c, 16'h0);
    check("timeout lane b kept", b, 16'h4001);
    for (int i = 0; i < 8; i++) exp[i] = 16'h4000 + 16'(i);
    check_lanes_nt("no-timeout frame", exp);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    send_frame("after timeout", 16'h5000);
    step(1'b0, 1'b0, 16'h0, 1'b1);

    // Accept on the timeout cycle wins.
    step(1'b1, 1'b1, 16'h4100, 1'b0);
    repeat (14) step(1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b0, 16'h4101, 1'b0);
    check("accept on timeout cycle err", frame_err, 1'b0);
    step(1'b1, 1'b0, 16'h4102, 1'b0);
    check("still collecting err", frame_err, 1'b0);
    check("still collecting lane c", c, 16'h4102);

    // Reset after word 5, then during HOLD.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, i == 0, 16'h6000 + 16'(i), 1'b0);
    do_reset();
    check_ctl("reset mid-frame", 1'b1, 1'b0, 1'b0);
    check_lanes("reset mid-frame", zeros);
    send_frame("post reset", 16'h7000);
    do_reset();
    check_ctl("reset in hold", 1'b1, 1'b0, 1'b0);
    check_lanes("reset in hold", zeros);
    send_frame("post hold reset", 16'h7100);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    check_ctl("final ack", 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
